sha256_compress: RTL
====================

// Module: sha256_compress
// PURPOSE
//   Iterative SHA-256 compression core: accepts one 512-bit block as 16 streamed 32-bit words,
//   runs 64 rounds (one per clock), adds the result into the chaining hash, presents the 256-bit digest.
//   Consumes the rotate-right primitives (Sigma0 = rotr2^rotr13^rotr22, Sigma1, sigma0/1);
//   sits between the message padder (upstream) and the hash output port (downstream).
// PARAMETERS
//   NROUNDS  64  rounds per block; 64 = compliant, 16..63 only for reduced-round test builds
// PORTS
//   clk          in   1    single clock, all state on rising edge
//   rst          in   1    asynchronous, active-high reset
//   first_block  in   1    sampled with word 0: 1 = start from IV, 0 = chain from current H
//   word_valid   in   1    message word valid
//   word_ready   out  1    core accepts a word this cycle
//   word_data    in   32   message word, big-endian, W0 first
//   digest_valid out  1    digest available
//   digest_ready in   1    downstream takes digest
//   digest       out  256  {H0..H7}, H0 in [255:224]
//   busy         out  1    high in ROUND/FINAL/OUT
// BEHAVIOUR
//   Reset: state=RECV, word_cnt=0, t=0, H=IV, a..h=0, digest_valid=0, busy=0; digest shows IV.
//   States: RECV -> ROUND -> FINAL -> OUT -> RECV.
//   RECV: word_ready=1. Word handshake = valid&&ready; word i written to W ring slot i.
//     Word 0: if first_block, H<=IV; a..h then load from (updated) H on word-15 handshake.
//     On word-15 handshake: a..h<=H, t<=0, go ROUND.
//   ROUND (cycles k+1..k+NROUNDS, k = word-15 handshake cycle): word_ready=0.
//     t<16: W_t = ring[t]; t>=16: W_t = sigma1(ring[t-2])+ring[t-7]+sigma0(ring[t-15])+ring[t-16],
//     written to ring[t mod 16] same cycle. Standard round update with K[t]; all adds mod 2^32.
//     t==NROUNDS-1 -> FINAL.
//   FINAL (cycle k+NROUNDS+1): H_i <= H_i + {a..h}_i mod 2^32; go OUT.
//   OUT (from k+NROUNDS+2): digest_valid=1, digest=H, stable until digest_ready; on handshake -> RECV
//     same edge, digest_valid low next cycle. Latency word-15 -> digest_valid = NROUNDS+2 (66).
//   H retained after OUT, so next block with first_block=0 chains. digest_ready ignored outside OUT.
//   word_valid ignored outside RECV; words are not buffered.
//   first_block on words 1..15 ignored. Partial block (word_cnt<16) waits indefinitely; no timeout.
//   rst at any cycle (incl. mid-ROUND, mid-OUT) aborts: returns to reset values next edge, partial
//     block and chained H discarded; digest_valid drops asynchronously with rst.
// STRUCTURE
//   sha256_pkg: K[0:63] constant array, IV[0:7], state enum, functions big_sigma0/1, small_sigma0/1, ch, maj
//     (big_sigma0 built from rotright2/rotright13/rotright22 rotate modules or equivalent functions).
//   Sub-module sha256_msg_sched: 16x32 W ring, write port for RECV words, returns W_t and self-updates
//     for t>=16. Core holds FSM, counters, a..h, H.
// TESTING
//   1) "abc": first_block=1, words 61626380, 14x00000000, 00000018 -> digest
//      ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, valid exactly 66 cycles after word 15.
//   2) Empty msg: 80000000, 15x00000000 -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
//   3) Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 first_block=1, block 2
//      first_block=0 -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//   4) Backpressure: "abc", digest_ready=0 for 20 cycles -> digest_valid held, digest unchanged, word_ready=0;
//      word_valid toggled randomly during RECV -> same digest.
//   5) Reset mid-op: rst pulse at round t=30 of "abc" -> digest_valid=0, word_ready=1 next cycle;
//      rerun "abc" -> test 1 digest.
//   6) Back-to-back: test 2 then test 1 with first_block=1 each, digest_ready=1 -> both digests correct, no stale chaining.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and round/schedule primitives
// shared by the compression core and its message schedule.
package sha256_pkg;

    typedef enum logic [1:0] {
        S_RECV,
        S_ROUND,
        S_FINAL,
        S_OUT
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr2(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    function automatic logic [31:0] rotr13(input logic [31:0] x);
        return {x[12:0], x[31:13]};
    endfunction

    function automatic logic [31:0] rotr22(input logic [31:0] x);
        return {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr2(x) ^ rotr13(x) ^ rotr22(x);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z
    );
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z
    );
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-entry rolling message schedule: filled by streamed words,
// then expands W_t in place for rounds t >= 16.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic        round_i,
    input  logic [5:0]  t_i,
    output logic [31:0] wt_o
);

    logic [31:0] ring_q [16];
    logic [3:0]  slot;
    logic        expand;
    logic [31:0] w_exp;

    assign slot   = t_i[3:0];
    assign expand = |t_i[5:4];

    // slot+14, +9, +1, +0 are t-2, t-7, t-15, t-16 modulo the ring size
    assign w_exp = small_sigma1(ring_q[slot + 4'd14])
                 + ring_q[slot + 4'd9]
                 + small_sigma0(ring_q[slot + 4'd1])
                 + ring_q[slot];

    assign wt_o = expand ? w_exp : ring_q[slot];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                ring_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            ring_q[wr_idx_i] <= wr_data_i;
        end else if (round_i && expand) begin
            ring_q[slot] <= w_exp;
        end
    end

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression core: one round per clock,
// chaining hash kept between blocks until first_block restarts it.
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int NROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         first_block,
    input  logic         word_valid,
    output logic         word_ready,
    input  logic [31:0]  word_data,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [5:0]  t_q;
    logic [31:0] v_q [8];
    logic [31:0] h_q [8];
    logic [31:0] v_d [8];
    logic        rdy_q;
    logic        busy_q;
    logic        dvalid_q;

    logic        word_hs;
    logic [31:0] wt;
    logic [31:0] t1;
    logic [31:0] t2;

    assign word_hs = word_valid && rdy_q;

    sha256_msg_sched u_sched (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (word_hs),
        .wr_idx_i  (cnt_q),
        .wr_data_i (word_data),
        .round_i   (state_q == S_ROUND),
        .t_i       (t_q),
        .wt_o      (wt)
    );

    always_comb begin
        t1 = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6])
           + K[t_q] + wt;
        t2 = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
        v_d[0] = t1 + t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RECV;
            cnt_q    <= '0;
            t_q      <= '0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            dvalid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= IV[i];
                v_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_RECV: begin
                    if (word_hs) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd0 && first_block) begin
                            for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
                        end
                        if (cnt_q == 4'd15) begin
                            for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
                            t_q     <= '0;
                            state_q <= S_ROUND;
                            rdy_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    for (int i = 0; i < 8; i++) v_q[i] <= v_d[i];
                    t_q <= t_q + 6'd1;
                    if (t_q == 6'(NROUNDS - 1)) begin
                        state_q <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
                    state_q  <= S_OUT;
                    dvalid_q <= 1'b1;
                end
                S_OUT: begin
                    if (digest_ready) begin
                        state_q  <= S_RECV;
                        dvalid_q <= 1'b0;
                        busy_q   <= 1'b0;
                        rdy_q    <= 1'b1;
                    end
                end
                default: state_q <= S_RECV;
            endcase
        end
    end

    assign word_ready   = rdy_q;
    assign busy         = busy_q;
    assign digest_valid = dvalid_q;
    assign digest = {h_q[0], h_q[1], h_q[2], h_q[3],
                     h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule
